// File: rtl/div_unit.sv
// Iterative restoring divider for the execute stage: one quotient bit per cycle, signed or
// unsigned, freezing the pipeline through div_stall until the result is ready.
module div_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_signed_mode,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_flush,
  output logic             o_div_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic [WIDTH:0]   r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_quo, w_quo_nxt;
  logic [WIDTH-1:0] r_dvsr, w_dvsr_nxt;
  logic             r_neg_q, w_neg_q_nxt;
  logic             r_neg_r, w_neg_r_nxt;
  logic [WIDTH-1:0] r_quotient, w_quotient_nxt;
  logic [WIDTH-1:0] r_remainder, w_remainder_nxt;
  logic             r_dbz, w_dbz_nxt;

  logic             w_accept;
  logic             w_dvd_neg, w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs;
  logic [WIDTH:0]   w_shift, w_trial;

  assign w_accept  = (r_state == StIdle) && i_start && !i_flush;
  assign w_dvd_neg = i_signed_mode && i_dividend[WIDTH-1];
  assign w_dvs_neg = i_signed_mode && i_divisor[WIDTH-1];
  assign w_dvd_abs = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_abs = w_dvs_neg ? -i_divisor : i_divisor;

  // Partial remainder stays below the divisor, so the shifted value never overflows WIDTH+1 bits
  // and the trial result's MSB is a clean borrow flag.
  assign w_shift = (r_rem << 1) | {{WIDTH{1'b0}}, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvsr};

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rem_nxt       = r_rem;
    w_quo_nxt       = r_quo;
    w_dvsr_nxt      = r_dvsr;
    w_neg_q_nxt     = r_neg_q;
    w_neg_r_nxt     = r_neg_r;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
    w_dbz_nxt       = r_dbz;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (i_divisor == '0) begin
            w_state_nxt     = StDone;
            w_quotient_nxt  = '1;
            w_remainder_nxt = i_dividend;
            w_dbz_nxt       = 1'b1;
          end else begin
            w_state_nxt = StCalc;
            w_cnt_nxt   = '0;
            w_rem_nxt   = '0;
            w_quo_nxt   = w_dvd_abs;
            w_dvsr_nxt  = w_dvs_abs;
            w_neg_q_nxt = w_dvd_neg ^ w_dvs_neg;
            w_neg_r_nxt = w_dvd_neg;
            w_dbz_nxt   = 1'b0;
          end
        end
      end
      StCalc: begin
        // Dividend bits shift out of r_quo's top as quotient bits shift in at the bottom.
        w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        w_rem_nxt = w_trial[WIDTH] ? w_shift : w_trial;
        w_cnt_nxt = r_cnt + CntOne;
        if (r_cnt == CntLast) begin
          w_state_nxt = StFix;
        end
      end
      StFix: begin
        w_quotient_nxt  = r_neg_q ? -r_quo : r_quo;
        w_remainder_nxt = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        w_state_nxt     = StDone;
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    // A squashed instruction must leave the visible result untouched.
    if (i_flush) begin
      w_state_nxt     = StIdle;
      w_quotient_nxt  = r_quotient;
      w_remainder_nxt = r_remainder;
      w_dbz_nxt       = r_dbz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rem       <= w_rem_nxt;
      r_quo       <= w_quo_nxt;
      r_dvsr      <= w_dvsr_nxt;
      r_neg_q     <= w_neg_q_nxt;
      r_neg_r     <= w_neg_r_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
      r_dbz       <= w_dbz_nxt;
    end
  end

  // Stall rises combinationally with start so the pipeline freezes in the issue cycle.
  assign o_div_stall   = w_accept || (r_state == StCalc) || (r_state == StFix);
  assign o_done        = (r_state == StDone) && !i_flush;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: an arithmetic reference model checked every cycle, plus
// hand-computed result and latency expectations for each vector.
module tb_div_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, signed_mode, flush;
  logic [W-1:0] dividend, divisor;
  logic         div_stall, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  logic chk_en = 1'b0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_signed_mode(signed_mode),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .i_flush      (flush),
    .o_div_stall  (div_stall),
    .o_done       (done),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [31:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    int x, y, q, r;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    q = x / y;
    r = x % y;
    return {q[15:0], r[15:0]};
  endfunction

  // Reference model: a busy countdown plus C-style truncating arithmetic.
  int           m_busy = 0;
  logic         m_in_done = 1'b0;
  logic [31:0]  m_pend = '0;
  logic [W-1:0] m_out_q = '0, m_out_r = '0;
  logic         m_out_z = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 0;
      m_in_done <= 1'b0;
      m_out_q   <= '0;
      m_out_r   <= '0;
      m_out_z   <= 1'b0;
    end else if (flush) begin
      m_busy    <= 0;
      m_in_done <= 1'b0;
    end else if (m_in_done) begin
      m_in_done <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_in_done <= 1'b1;
        m_out_q   <= m_pend[31:16];
        m_out_r   <= m_pend[15:0];
      end
    end else if (start) begin
      if (divisor == '0) begin
        m_in_done <= 1'b1;
        m_out_q   <= '1;
        m_out_r   <= dividend;
        m_out_z   <= 1'b1;
      end else begin
        m_busy  <= W + 1;
        m_pend  <= ref_div(dividend, divisor, signed_mode);
        m_out_z <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, div_stall},
          {31'b0, (m_busy > 0) || (!m_in_done && start && !flush)});
      chk("done", {31'b0, done}, {31'b0, m_in_done && !flush});
      chk("quotient", {16'b0, quotient}, {16'b0, m_out_q});
      chk("remainder", {16'b0, remainder}, {16'b0, m_out_r});
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_out_z});
    end
    if (done) n_done++;
  end

  // Called at posedge+1; returns at posedge+1 with start dropped after the done cycle.
  task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int exp_stall);
    int stall_cnt = 0;
    int done_cyc  = 0;
    start       = 1'b1;
    signed_mode = s;
    dividend    = a;
    divisor     = b;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (div_stall) stall_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({name, "_stall_cycles"}, stall_cnt, exp_stall);
    chk({name, "_done_cycle"}, done_cyc, exp_stall + 1);
    chk({name, "_q"}, {16'b0, quotient}, {16'b0, eq});
    chk({name, "_r"}, {16'b0, remainder}, {16'b0, er});
    chk({name, "_z"}, {31'b0, div_by_zero}, {31'b0, ez});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int nd0;
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    flush = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_q", {16'b0, quotient}, 32'h0);
    chk("reset_r", {16'b0, remainder}, 32'h0);
    chk("reset_z_done_stall", {29'b0, div_by_zero, done, div_stall}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    run_div("u100_7", 16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 18);
    run_div("sm100_7", 16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 18);
    run_div("s100_m7", 16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 18);
    run_div("dbz", 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1);
    run_div("u6_3", 16'h0006, 16'h0003, 1'b0, 16'h0002, 16'h0000, 1'b0, 18);
    run_div("s_ovf", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 18);
    run_div("uffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 18);

    // Back-to-back: start held through DONE, next instruction two cycles after done.
    nd0 = n_done;
    run_div("b2b_a", 16'h03E8, 16'h000A, 1'b0, 16'h0064, 16'h0000, 1'b0, 18);
    @(posedge clk);
    #1;
    run_div("b2b_b", 16'h0031, 16'h0005, 1'b0, 16'h0009, 16'h0004, 1'b0, 18);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_done_count", n_done - nd0, 2);

    // Flush on CALC cycle 8.
    nd0 = n_done;
    start = 1'b1;
    dividend = 16'h0200;
    divisor = 16'h0003;
    repeat (8) @(posedge clk);
    #1;
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("flush_stall_same_cycle", {31'b0, div_stall}, 32'h1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_stall_dropped", {31'b0, div_stall}, 32'h0);
    chk("flush_q_kept", {16'b0, quotient}, 32'h0009);
    chk("flush_r_kept", {16'b0, remainder}, 32'h0004);
    repeat (25) @(posedge clk);
    #1;
    chk("flush_no_done", n_done - nd0, 0);

    // Reset on CALC cycle 5.
    nd0 = n_done;
    start = 1'b1;
    dividend = 16'h0100;
    divisor = 16'h0005;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_q", {16'b0, quotient}, 32'h0);
    chk("rst_r", {16'b0, remainder}, 32'h0);
    chk("rst_z_done_stall", {29'b0, div_by_zero, done, div_stall}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("rst_no_done", n_done - nd0, 0);
    chk("rst_idle_stall", {31'b0, div_stall}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle 16-bit integer divider in the execute stage of the 5-stage pipeline.
- Produces quotient and remainder for signed and unsigned divide instructions.
- Drives the pipeline-freeze signal that the control unit samples as its DivStall input. This block is the responder side of the DivStall handshake.
- Holds the pipeline frozen until the result is valid, then releases it for exactly one advancing cycle.

Parameters:
WIDTH, 16, operand/result width in bits. The iteration count equals WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  divide instruction present in execute stage; held high while the instruction is stalled there
signed_mode  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start
dividend  in  WIDTH  numerator, sampled with start in IDLE
divisor  in  WIDTH  denominator, sampled with start in IDLE
flush  in  1  kill in-flight divide (branch/jump squash)
div_stall  out  1  pipeline freeze request (to control DivStall)
done  out  1  one-cycle pulse: quotient/remainder valid this cycle
quotient  out  WIDTH  result quotient
remainder  out  WIDTH  result remainder
div_by_zero  out  1  set with done when divisor was 0

Behaviour:
- States: IDLE, CALC, FIX, DONE. Use a 2-bit state register, a counter of clog2(WIDTH)+1 bits, partial-remainder register (WIDTH+1 bits), quotient shift register, and latched sign flags.
- Reset: state=IDLE, counter=0, quotient=0, remainder=0, div_by_zero=0, done=0. div_stall=0 unless start is high in IDLE.
- div_stall is combinational: (IDLE & start & !flush) | CALC | FIX. It must rise in the same cycle start first appears, so the pipeline freezes immediately.
- IDLE, start=1, divisor≠0:
  - Latch the absolute values of the operands (signed_mode only; unsigned passes through).
  - Latch neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Go to CALC with counter=0.
- IDLE, start=1, divisor=0:
  - Go directly to DONE.
  - quotient ← all ones (0xFFFF), remainder ← dividend unmodified, div_by_zero ← 1.
  - Total stall is 1 cycle.
- CALC: one restoring-division step per cycle, MSB first.
  - Shift {rem, dividend-bit} left.
  - Trial subtract divisor; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
  - After WIDTH cycles (counter==WIDTH-1), go to FIX.
- FIX (1 cycle):
  - If neg_q, quotient ← two's complement of the magnitude.
  - If neg_r, remainder ← two's complement.
  - Go to DONE. Remainder sign follows the dividend (truncating division).
- Signed overflow case: 0x8000 / 0xFFFF yields quotient 0x8000, remainder 0, div_by_zero=0. This falls out of magnitude arithmetic with no special casing.
- DONE (1 cycle):
  - done=1, div_stall=0, so the pipeline advances at this edge. Next state is IDLE.
  - start is still high during DONE (same instruction). It must NOT retrigger.
  - A start seen in the following IDLE cycle belongs to the next instruction.
- Latency: normal divide stalls WIDTH+2 = 18 cycles (IDLE-start, 16×CALC, FIX); done asserts on cycle 19.
- Outputs quotient/remainder/div_by_zero hold their last values until the next DONE. div_by_zero clears at the start of the next accepted divide.
- flush:
  - In any state, flush forces IDLE next cycle, no done pulse, result registers unchanged.
  - flush with start in IDLE: the divide is not accepted and div_stall=0.
- start is ignored in CALC/FIX. Operand changes during CALC have no effect.
- rst asserted mid-operation: immediate return to reset values, no done pulse.

Test Plan:
- Unsigned 100/7 (0x0064/0x0007): div_stall high for exactly 18 cycles from the start cycle; done on cycle 19 with quotient=0x000E, remainder=0x0002, div_by_zero=0.
- Signed -100/7 (0xFF9C/0x0007): quotient=0xFFF2 (-14), remainder=0xFFFE (-2). Signed 100/-7: quotient=0xFFF2, remainder=0x0002.
- Divide by zero, 0x1234/0x0000: div_stall high 1 cycle; done the next cycle with quotient=0xFFFF, remainder=0x1234, div_by_zero=1. A following 6/3 clears div_by_zero and gives quotient=2.
- Signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0x0000. Unsigned 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0.
- Back-to-back: start held high through DONE, then a new start two cycles later. Exactly one done per instruction; the second result is correct.
- Abort cases, each checked independently:
  - rst pulsed on CALC cycle 5: all outputs reset, state IDLE.
  - flush on CALC cycle 8: no done pulse, div_stall drops the next cycle, previous quotient/remainder retained.
